// File: rtl/row_pixel_packer_pkg.sv
// row_pixel_packer_pkg
// Purpose: constants and types shared between the row packer (write side)
//          and the row unpacking FIFO (read side). Both sides take their
//          pixel width and lane count from here, so the two cannot disagree
//          about which lane holds which pixel.
// Contents: PIX_W, PIX_PER_WORD, WORD_W, the packer FSM state encoding and
//           the words_per_row() helper.
package row_pixel_packer_pkg;

  localparam int PIX_W        = 8;
  localparam int PIX_PER_WORD = 8;
  localparam int WORD_W       = PIX_W * PIX_PER_WORD;
  localparam int LANE_W       = $clog2(PIX_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PACK = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A row always starts a fresh word, so a partial last word still costs a
  // whole address.
  function automatic int words_per_row(input int row_len);
    return (row_len + PIX_PER_WORD - 1) / PIX_PER_WORD;
  endfunction

endpackage

// File: rtl/row_pixel_packer_if.sv
// row_pixel_packer_if
// Purpose: groups the pixel stream handshake and the BRAM port A write bus.
// Signals:
//   pix_data/pix_valid  pixel source -> packer
//   pix_ready           packer -> pixel source
//   ena/wea/addra/dina  packer -> BRAM port A
// Modports: slave (the packer), master (the source/sink side).
interface row_pixel_packer_if #(
  parameter int ADDR_W = 8
);
  import row_pixel_packer_pkg::*;

  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [WORD_W-1:0] dina;

  modport slave (
    input  pix_data, pix_valid,
    output pix_ready, ena, wea, addra, dina
  );

  modport master (
    output pix_data, pix_valid,
    input  pix_ready, ena, wea, addra, dina
  );

endinterface

// File: rtl/row_pixel_packer_word_assembler.sv
// row_pixel_packer_word_assembler
// Purpose: collects accepted pixels LSB-first into one BRAM word and emits
//          the completed word with a one-cycle write strobe.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clear_i      start of a frame: drop any partial word
//   pix_we_i     a pixel is accepted this cycle
//   pix_i        the accepted pixel
//   last_i       the accepted pixel ends its row (forces a partial word out)
//   complete_o   combinational: this accept finishes a word
//   word_o       registered completed word (valid while wr_o is high)
//   wr_o         registered write strobe, one cycle after the completing accept
module row_pixel_packer_word_assembler
  import row_pixel_packer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              pix_we_i,
  input  logic [PIX_W-1:0]  pix_i,
  input  logic              last_i,
  output logic              complete_o,
  output logic [WORD_W-1:0] word_o,
  output logic              wr_o
);

  logic [LANE_W-1:0] lane_q;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] out_q;
  logic              wr_q;

  // Current pixel merged into its lane; lanes above it are still 0, which
  // is exactly the zero fill a short row-end word needs.
  always_comb begin
    word_d = word_q;
    word_d[lane_q*PIX_W +: PIX_W] = pix_i;
  end

  assign complete_o = pix_we_i & ((lane_q == LANE_W'(PIX_PER_WORD - 1)) | last_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= '0;
      word_q <= '0;
      out_q  <= '0;
      wr_q   <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      if (clear_i) begin
        lane_q <= '0;
        word_q <= '0;
      end else if (pix_we_i) begin
        if (complete_o) begin
          lane_q <= '0;
          word_q <= '0;
          out_q  <= word_d;
          wr_q   <= 1'b1;
        end else begin
          lane_q <= lane_q + 1'b1;
          word_q <= word_d;
        end
      end
    end
  end

  assign word_o = out_q;
  assign wr_o   = wr_q;

endmodule

// File: rtl/row_pixel_packer.sv
// row_pixel_packer
// Purpose: accepts output pixels one per cycle and writes them, packed
//          LSB-first, into BRAM port A. Every row starts on a fresh word.
// Ports:
//   clk, reset   clock, synchronous active-high reset (priority over all)
//   start        frame start pulse, honoured only in IDLE
//   base_addr    first word address, latched on an accepted start
//   bus          pixel handshake + BRAM port A (slave modport)
//   row_done     pulse with the write of a row's last word
//   frame_done   pulse with the write of the frame's last word
//   busy         high whenever not IDLE
//
// state | meaning
// IDLE  | waiting for start, pix_ready low
// PACK  | accepting pixels, pix_ready high
// DONE  | one cycle after the frame's last accept, last write goes out
module row_pixel_packer
  import row_pixel_packer_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int ROW_LEN  = 30,
  parameter int NUM_ROWS = 30
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  row_pixel_packer_if.slave bus,
  output logic              row_done,
  output logic              frame_done,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [7:0]        col_q, row_q;
  logic [ADDR_W-1:0] addr_q, addra_q;
  logic              row_done_q, frame_done_q;
  logic              start_ok, accept, last_col, last_row, complete, wr;
  logic [WORD_W-1:0] word;

  assign start_ok = (state_q == ST_IDLE) & start;
  assign accept   = (state_q == ST_PACK) & bus.pix_valid;
  assign last_col = (col_q == 8'(ROW_LEN - 1));
  assign last_row = (row_q == 8'(NUM_ROWS - 1));

  row_pixel_packer_word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (start_ok),
    .pix_we_i   (accept),
    .pix_i      (bus.pix_data),
    .last_i     (last_col),
    .complete_o (complete),
    .word_o     (word),
    .wr_o       (wr)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_PACK;
      ST_PACK: if (accept && last_col && last_row) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      addra_q      <= '0;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (start_ok) begin
        addr_q <= base_addr;
        col_q  <= '0;
        row_q  <= '0;
      end else if (accept) begin
        if (last_col) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
        // Address is captured at the completing accept so it lines up with
        // the assembler's registered word one cycle later.
        if (complete) begin
          addra_q      <= addr_q;
          addr_q       <= addr_q + 1'b1;
          row_done_q   <= last_col;
          frame_done_q <= last_col & last_row;
        end
      end
    end
  end

  assign bus.pix_ready = (state_q == ST_PACK);
  assign bus.ena       = wr;
  assign bus.wea       = wr;
  assign bus.addra     = addra_q;
  assign bus.dina      = word;
  assign row_done      = row_done_q;
  assign frame_done    = frame_done_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_row_pixel_packer.sv
// tb_row_pixel_packer
// Four packer instances with different row/frame geometry share one clock.
// A frame-level model records every accepted pixel and, whenever a pixel
// ends a word, builds the expected word from the stored row pixels; one
// compare process checks all outputs of all instances every cycle.
module tb_row_pixel_packer;
  import row_pixel_packer_pkg::*;

  localparam int N = 4;

  function automatic int rl_of(input int i);
    case (i)
      0: return 8;
      1: return 30;
      2: return 30;
      default: return 24;
    endcase
  endfunction

  function automatic int nr_of(input int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 30;
      default: return 1;
    endcase
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] reset_v, start_v, pix_valid_v;
  logic [7:0]   base_a     [N];
  logic [7:0]   pix_data_a [N];
  logic [N-1:0] pix_ready_v, ena_v, wea_v, row_v, fr_v, busy_v;
  logic [7:0]   addra_a [N];
  logic [63:0]  dina_a  [N];

  for (genvar g = 0; g < N; g++) begin : gi
    row_pixel_packer_if #(.ADDR_W(8)) bus ();
    assign bus.pix_data  = pix_data_a[g];
    assign bus.pix_valid = pix_valid_v[g];
    assign pix_ready_v[g] = bus.pix_ready;
    assign ena_v[g]       = bus.ena;
    assign wea_v[g]       = bus.wea;
    assign addra_a[g]     = bus.addra;
    assign dina_a[g]      = bus.dina;

    row_pixel_packer #(.ADDR_W(8), .ROW_LEN(rl_of(g)), .NUM_ROWS(nr_of(g))) dut (
      .clk        (clk),
      .reset      (reset_v[g]),
      .start      (start_v[g]),
      .base_addr  (base_a[g]),
      .bus        (bus),
      .row_done   (row_v[g]),
      .frame_done (fr_v[g]),
      .busy       (busy_v[g])
    );
  end

  // ---------------- behavioural model ----------------
  // m_state: 0 idle, 1 accepting, 2 one cycle after the last accept
  int          m_state [N];
  int          m_cnt   [N];
  int          m_words [N];
  logic [7:0]  m_base  [N];
  logic        m_clean [N];
  logic [7:0]  store   [N][1024];
  logic        e_wv    [N];
  logic        e_row   [N];
  logic        e_fr    [N];
  logic [7:0]  e_wa    [N];
  logic [63:0] e_wd    [N];

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      automatic int rl    = rl_of(i);
      automatic int total = rl_of(i) * nr_of(i);
      automatic int k, c, w0;
      automatic logic [63:0] wd;
      if (reset_v[i]) begin
        m_state[i] <= 0;
        m_clean[i] <= 1'b1;
        e_wv[i]    <= 1'b0;
        e_row[i]   <= 1'b0;
        e_fr[i]    <= 1'b0;
      end else begin
        e_wv[i]  <= 1'b0;
        e_row[i] <= 1'b0;
        e_fr[i]  <= 1'b0;
        case (m_state[i])
          0: if (start_v[i]) begin
               m_state[i] <= 1;
               m_base[i]  <= base_a[i];
               m_cnt[i]   <= 0;
               m_words[i] <= 0;
             end
          1: if (pix_valid_v[i]) begin
               k = m_cnt[i];
               c = k % rl;
               store[i][k] <= pix_data_a[i];
               if ((c % PIX_PER_WORD) == PIX_PER_WORD - 1 || c == rl - 1) begin
                 w0 = c - (c % PIX_PER_WORD);
                 wd = '0;
                 for (int j = 0; j < PIX_PER_WORD; j++) begin
                   if (w0 + j < c)       wd[8*j +: 8] = store[i][k - c + w0 + j];
                   else if (w0 + j == c) wd[8*j +: 8] = pix_data_a[i];
                 end
                 e_wv[i]    <= 1'b1;
                 e_wd[i]    <= wd;
                 e_wa[i]    <= 8'((int'(m_base[i]) + m_words[i]) % 256);
                 e_row[i]   <= (c == rl - 1);
                 e_fr[i]    <= (k == total - 1);
                 m_words[i] <= m_words[i] + 1;
                 m_clean[i] <= 1'b0;
               end
               m_cnt[i] <= k + 1;
               if (k == total - 1) m_state[i] <= 2;
             end
          default: m_state[i] <= 0;
        endcase
      end
    end
  end

  // ---------------- compare process ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic timeout_q = 1'b0;
  logic to_seen   = 1'b0;

  task automatic chk(input int i, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL inst%0d %s at %0t: got %h expected %h", i, nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      chk(i, "pix_ready",  64'(pix_ready_v[i]), 64'(m_state[i] == 1));
      chk(i, "busy",       64'(busy_v[i]),      64'(m_state[i] != 0));
      chk(i, "ena",        64'(ena_v[i]),       64'(e_wv[i]));
      chk(i, "wea",        64'(wea_v[i]),       64'(e_wv[i]));
      chk(i, "row_done",   64'(row_v[i]),       64'(e_row[i]));
      chk(i, "frame_done", 64'(fr_v[i]),        64'(e_fr[i]));
      if (e_wv[i]) begin
        chk(i, "addra", 64'(addra_a[i]), 64'(e_wa[i]));
        chk(i, "dina",  dina_a[i],       e_wd[i]);
        // hand-computed anchors for the model itself
        if (i == 0) begin
          chk(i, "lit_dina", dina_a[i], 64'h0807060504030201);
          chk(i, "lit_addra", 64'(addra_a[i]), 64'h10);
        end
        if (i == 1 && m_words[i] == 4) chk(i, "lit_row0_tail", dina_a[i], 64'h00001E1D1C1B1A19);
        if (i == 1 && m_words[i] == 8) begin
          chk(i, "lit_row1_tail", dina_a[i], 64'h00003C3B3A393837);
          chk(i, "lit_frame_done", 64'(fr_v[i]), 64'h1);
        end
        if (i == 2 && e_fr[i]) chk(i, "lit_last_addra", 64'(addra_a[i]), 64'd119);
        if (i == 3) begin
          case (m_words[i])
            1: chk(i, "lit_wrap0", 64'(addra_a[i]), 64'hFE);
            2: chk(i, "lit_wrap1", 64'(addra_a[i]), 64'hFF);
            3: chk(i, "lit_wrap2", 64'(addra_a[i]), 64'h00);
            default: ;
          endcase
        end
      end else if (m_clean[i]) begin
        chk(i, "addra_rst", 64'(addra_a[i]), 64'h0);
        chk(i, "dina_rst",  dina_a[i],       64'h0);
      end
    end
    if (timeout_q && !to_seen) begin
      to_seen <= 1'b1;
      n_cmp++;
      n_bad++;
      $display("FAIL timeout at %0t: got no frame completion, expected one within budget", $time);
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_frame(input int i, input logic [7:0] base, input int gap,
                           input int n_pix, input int mid_start_at, input int mul);
    int sent = 0;
    int cyc = 0;
    int budget = n_pix * 4 + 50;
    logic r;
    @(negedge clk);
    start_v[i] = 1'b1;
    base_a[i]  = base;
    @(negedge clk);
    start_v[i] = 1'b0;
    base_a[i]  = 8'($urandom);
    while (sent < n_pix) begin
      r = pix_ready_v[i];
      if (cyc == mid_start_at) begin
        start_v[i] = 1'b1;
        base_a[i]  = 8'h30;
      end else begin
        start_v[i] = 1'b0;
      end
      if ($urandom_range(99) >= gap) begin
        pix_valid_v[i] = 1'b1;
        pix_data_a[i]  = 8'(sent * mul + 1);
      end else begin
        pix_valid_v[i] = 1'b0;
        pix_data_a[i]  = 8'($urandom);
      end
      @(negedge clk);
      if (pix_valid_v[i] && r) sent++;
      cyc++;
      if (cyc > budget) begin
        timeout_q = 1'b1;
        break;
      end
    end
    pix_valid_v[i] = 1'b0;
    start_v[i]     = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int cyc = 0;
    while (busy_v[i] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (busy_v[i]) timeout_q = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset_v     = '1;
    start_v     = '0;
    pix_valid_v = '1;
    for (int i = 0; i < N; i++) begin
      base_a[i]     = 8'($urandom);
      pix_data_a[i] = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    reset_v = '0;
    repeat (5) @(negedge clk);
    pix_valid_v = '0;

    run_frame(0, 8'h10, 0, 8, -1, 1);
    wait_idle(0);

    run_frame(1, 8'h00, 0, 60, -1, 1);
    wait_idle(1);

    run_frame(2, 8'h00, 0, 900, -1, 7);
    wait_idle(2);
    run_frame(2, 8'h00, 50, 900, -1, 7);
    wait_idle(2);

    run_frame(3, 8'hFE, 0, 24, 5, 1);
    wait_idle(3);

    // Reset mid-row, with a start in the same cycle that must be ignored.
    run_frame(1, 8'h40, 0, 5, -1, 1);
    reset_v[1] = 1'b1;
    start_v[1] = 1'b1;
    @(negedge clk);
    reset_v[1] = 1'b0;
    start_v[1] = 1'b0;
    repeat (3) @(negedge clk);
    run_frame(1, 8'h80, 30, 60, -1, 1);
    wait_idle(1);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
